image_write_seq: RTL and testbench

IMAGE_WRITE_SEQ -- requirements
Module: image_write_seq

---
 rtl/image_write_seq.sv | 123 ++++++++++++
 tb/tb_image_write_seq.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/image_write_seq.sv
// Frame sequencer: accepts pixel pairs from upstream, buffers them, and presents
// them one per hsync strobe with their row/column until WIDTH*HEIGHT/2 pairs are out.
module image_write_seq #(
  parameter int WIDTH      = 1680,
  parameter int HEIGHT     = 1050,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                          HCLK,
  input  logic                                          HRESETn,
  input  logic                                          start,
  input  logic                                          abort,
  input  logic                                          pix_valid,
  output logic                                          pix_ready,
  input  logic [47:0]                                   pix_data,
  output logic                                          hsync,
  output logic [7:0]                                    DATA_WRITE_R0,
  output logic [7:0]                                    DATA_WRITE_G0,
  output logic [7:0]                                    DATA_WRITE_B0,
  output logic [7:0]                                    DATA_WRITE_R1,
  output logic [7:0]                                    DATA_WRITE_G1,
  output logic [7:0]                                    DATA_WRITE_B1,
  output logic [$clog2(WIDTH/2)-1:0]                    col,
  output logic [((HEIGHT > 1) ? $clog2(HEIGHT) : 1)-1:0] row,
  output logic                                          busy,
  output logic                                          frame_done
);

  localparam int TOTAL = WIDTH * HEIGHT / 2;
  localparam int CW    = $clog2(WIDTH / 2);
  localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CNTW  = $clog2(TOTAL + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state;
  logic [CNTW-1:0] acc_cnt, out_cnt;
  logic [47:0]     mem [FIFO_DEPTH];
  logic [AW:0]     wp, rp;
  logic [CW-1:0]   nxt_col;
  logic [RW-1:0]   nxt_row;
  logic            run, empty, full, push, pop, wr_en, rd_en, last;
  logic [47:0]     pop_data;

  assign run      = (state == S_RUN);
  assign empty    = (wp == rp);
  assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pix_ready = run && !full && (acc_cnt < CNTW'(TOTAL));
  assign push     = pix_valid && pix_ready;
  // An accepted pair with an empty FIFO bypasses storage so it is shown next cycle.
  assign pop      = run && (!empty || push);
  assign wr_en    = push && !empty;
  assign rd_en    = run && !empty;
  assign pop_data = empty ? pix_data : mem[rp[AW-1:0]];
  assign last     = (out_cnt == CNTW'(TOTAL - 1));
  assign busy     = run;

  always_ff @(posedge HCLK) begin
    if (wr_en && !abort) mem[wp[AW-1:0]] <= pix_data;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= S_IDLE;
      acc_cnt    <= '0;
      out_cnt    <= '0;
      wp         <= '0;
      rp         <= '0;
      nxt_col    <= '0;
      nxt_row    <= '0;
      col        <= '0;
      row        <= '0;
      hsync      <= 1'b0;
      frame_done <= 1'b0;
      {DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0,
       DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1} <= '0;
    end else if (abort) begin
      state      <= S_IDLE;
      wp         <= '0;
      rp         <= '0;
      hsync      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      hsync      <= pop;
      frame_done <= (state == S_DONE);
      case (state)
        S_IDLE: if (start) begin
          state   <= S_RUN;
          acc_cnt <= '0;
          out_cnt <= '0;
          wp      <= '0;
          rp      <= '0;
          nxt_col <= '0;
          nxt_row <= '0;
          col     <= '0;
          row     <= '0;
        end
        S_RUN:   if (pop && last) state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (push)  acc_cnt <= acc_cnt + 1'b1;
      if (wr_en) wp <= wp + 1'b1;
      if (rd_en) rp <= rp + 1'b1;
      if (pop) begin
        out_cnt <= out_cnt + 1'b1;
        {DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0,
         DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1} <= pop_data;
        col <= nxt_col;
        row <= nxt_row;
        if (nxt_col == CW'(WIDTH / 2 - 1)) begin
          nxt_col <= '0;
          nxt_row <= (nxt_row == RW'(HEIGHT - 1)) ? '0 : nxt_row + 1'b1;
        end else begin
          nxt_col <= nxt_col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_image_write_seq.sv
// Scoreboard bench for image_write_seq at 4x2 pixels (4 pairs per frame).
module tb_image_write_seq;
  localparam int W = 4, H = 2, D = 4, TOTAL = 4;

  logic        HCLK = 0, HRESETn = 0, start = 0, abort = 0, pix_valid = 0;
  logic [47:0] pix_data = '0;
  logic        pix_ready, hsync, busy, frame_done;
  logic [7:0]  r0, g0, b0, r1, g1, b1;
  logic [0:0]  col, row;

  image_write_seq #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .abort(abort),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .hsync(hsync), .DATA_WRITE_R0(r0), .DATA_WRITE_G0(g0), .DATA_WRITE_B0(b0),
    .DATA_WRITE_R1(r1), .DATA_WRITE_G1(g1), .DATA_WRITE_B1(b1),
    .col(col), .row(row), .busy(busy), .frame_done(frame_done)
  );

  always #5 HCLK = ~HCLK;

  typedef struct { logic [47:0] d; int r; int c; } exp_t;
  exp_t q[$];

  int          checks = 0, errors = 0;
  int          ecol = 0, erow = 0, outn = 0, hs_cnt = 0, fd_cnt = 0;
  int          hs0, fd0;
  logic        pend_fd = 0;
  logic [47:0] nd = 48'h010203040506;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic mon();
    exp_t e;
    chk("frame_done", frame_done, pend_fd);
    pend_fd = 0;
    if (frame_done) fd_cnt++;
    if (hsync) begin
      hs_cnt++;
      if (q.size() == 0) chk("spurious_hsync", hsync, 1'b0);
      else begin
        e = q.pop_front();
        chk("data", {r0, g0, b0, r1, g1, b1}, e.d);
        chk("row", row, e.r);
        chk("col", col, e.c);
        outn++;
        if (outn == TOTAL) pend_fd = 1;
      end
    end
  endtask

  task automatic step(input logic v, input logic s, input logic a);
    @(negedge HCLK);
    mon();
    start = s; abort = a; pix_valid = v; pix_data = nd;
    if (a) begin
      q.delete();
      pend_fd = 0;
    end else if (v && pix_ready) begin
      q.push_back('{nd, erow, ecol});
      nd = nd + 1;
      if (ecol == W / 2 - 1) begin ecol = 0; erow = (erow + 1) % H; end
      else ecol++;
    end
  endtask

  task automatic begin_frame();
    ecol = 0; erow = 0; outn = 0;
    step(0, 1, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_hsync"}, hsync, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, pix_ready, 0);
    chk({tag, "_fd"}, frame_done, 0);
    chk({tag, "_data"}, {r0, g0, b0, r1, g1, b1}, 0);
    chk({tag, "_pos"}, {row, col}, 0);
  endtask

  initial begin
    // Reset and idle with valid asserted
    pix_valid = 1;
    #1 chk_zero("reset");
    @(negedge HCLK); @(negedge HCLK);
    HRESETn = 1;
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    @(negedge HCLK);
    mon();
    chk_zero("idle");
    pix_valid = 0;

    // Back-to-back frame
    hs0 = hs_cnt; fd0 = fd_cnt;
    begin_frame();
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    chk("busy_run", busy, 1);
    step(1, 0, 0);
    chk("ready_after_total", pix_ready, 0);
    chk("hsync_4th", hsync, 1);
    idle(4);
    chk("b2b_hsyncs", hs_cnt - hs0, 4);
    chk("b2b_done", fd_cnt - fd0, 1);

    // Gapped input
    hs0 = hs_cnt; fd0 = fd_cnt;
    begin_frame();
    for (int i = 0; i < 12; i++) step((i % 3) == 0, 0, 0);
    idle(4);
    chk("gap_hsyncs", hs_cnt - hs0, 4);
    chk("gap_done", fd_cnt - fd0, 1);

    // Abort after two pairs, then a clean frame
    hs0 = hs_cnt; fd0 = fd_cnt;
    begin_frame();
    step(1, 0, 0); step(1, 0, 0);
    idle(2);
    step(0, 0, 1);
    idle(6);
    chk("abort_busy", busy, 0);
    chk("abort_hsyncs", hs_cnt - hs0, 2);
    chk("abort_done", fd_cnt - fd0, 0);
    hs0 = hs_cnt; fd0 = fd_cnt;
    begin_frame();
    for (int i = 0; i < 6; i++) step(1, 0, 0);
    idle(3);
    chk("reframe_hsyncs", hs_cnt - hs0, 4);
    chk("reframe_done", fd_cnt - fd0, 1);

    // start+abort together in IDLE; start during RUN
    step(0, 1, 1);
    idle(2);
    chk("start_abort_busy", busy, 0);
    hs0 = hs_cnt; fd0 = fd_cnt;
    begin_frame();
    step(1, 0, 0); step(1, 0, 0); step(1, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    idle(3);
    chk("restart_hsyncs", hs_cnt - hs0, 4);
    chk("restart_done", fd_cnt - fd0, 1);

    // Reset mid-frame
    begin_frame();
    step(1, 0, 0); step(1, 0, 0);
    #2 HRESETn = 0;
    #1 chk_zero("midreset");
    q.delete(); pend_fd = 0; outn = 0;
    @(negedge HCLK);
    HRESETn = 1;
    hs0 = hs_cnt; fd0 = fd_cnt;
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    chk("postreset_hsyncs", hs_cnt - hs0, 0);
    chk("postreset_done", fd_cnt - fd0, 0);
    chk("postreset_ready", pix_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
